// File: rtl/lcd_frame_capture.sv
// lcd_frame_capture: sink side of the LCD scan-out path. Packs the 2bpp pixel
// stream four pixels per byte (pixel 0 in bits [1:0]) and writes the bytes
// through a small FIFO into a linear capture framebuffer.
// Optional feature macro: LCD_CAPTURE_CRC_EN adds frame_crc (CRC-16-CCITT,
// poly 0x1021, init 0xFFFF, MSB-first) over every byte accepted in a frame.
// Write handshake: a byte transfers on a clk edge where wr_valid && wr_ready;
// once wr_valid is high, wr_addr/wr_data hold and wr_valid stays high until
// the transfer, except that reset abandons the pending write.
// MAX_W and MAX_H must be <= 255; FIFO_DEPTH must be a power of 2 (>= 2).
module lcd_frame_capture #(
    parameter int MAX_W      = 160,
    parameter int MAX_H      = 160,
    parameter int STRIDE     = 40,
    parameter int ADDR_W     = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_pix,
    input  logic [1:0]        pixel,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              enable,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic [7:0]        meas_width,
    output logic [7:0]        meas_height,
`ifdef LCD_CAPTURE_CRC_EN
    output logic [15:0]       frame_crc,
`endif
    output logic [1:0]        state_dbg
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [7:0] MAX_W8 = 8'(MAX_W);
    localparam logic [7:0] MAX_H8 = 8'(MAX_H);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_entry_t;

    state_t      state_q, state_d;
    logic        prev_h, prev_v;
    logic        vfall, vrise, hrise, active, start;
    logic [7:0]  x_q, x_d, line_q, line_d, cap_x, mw_d, mh_d;
    logic [7:0]  pack_q, pack_d;
    logic        line_ok;
    logic [ADDR_W-1:0] line_base;
    logic        push;
    wr_entry_t   push_entry;

    wr_entry_t   mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count_q;
    logic        fifo_empty, fifo_full, pop, do_push;

    // Blank edges are judged only on pixel-enable cycles, against the last sampled level.
    assign vfall  = ce_pix && prev_v && !vblank;
    assign vrise  = ce_pix && !prev_v && vblank;
    assign hrise  = ce_pix && !prev_h && hblank;
    assign active = ce_pix && !hblank && !vblank;
    assign start  = (state_q == S_ARMED) && enable && vfall;

    assign cap_x     = (x_q > MAX_W8) ? MAX_W8 : x_q;
    assign line_ok   = line_q < MAX_H8;
    assign line_base = ADDR_W'(line_q) * STRIDE_A;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign pop        = wr_valid && wr_ready;
    assign do_push    = push && (!fifo_full || pop);

    assign wr_valid  = !fifo_empty;
    assign wr_addr   = fifo_empty ? '0 : mem[rd_ptr].addr;
    assign wr_data   = fifo_empty ? '0 : mem[rd_ptr].data;
    assign busy      = (state_q != S_IDLE);
    assign state_dbg = state_q;

    // Sample the blank levels on each pixel-enable cycle for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_h <= 1'b0;
            prev_v <= 1'b0;
        end else if (ce_pix) begin
            prev_h <= hblank;
            prev_v <= vblank;
        end
    end

    // Next-state logic; frame_done marks the DRAIN cycle where the FIFO is empty.
    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE:    if (enable) state_d = S_ARMED;
            S_ARMED: begin
                if (!enable)    state_d = S_IDLE;
                else if (vfall) state_d = S_CAPTURE;
            end
            S_CAPTURE: if (vrise) state_d = S_DRAIN;
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d    = S_IDLE;
                    frame_done = !reset;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Pixel packing, line/frame bookkeeping and byte push requests.
    always_comb begin
        x_d        = x_q;
        line_d     = line_q;
        pack_d     = pack_q;
        mw_d       = meas_width;
        mh_d       = meas_height;
        push       = 1'b0;
        push_entry = '0;
        if (start) begin
            x_d    = '0;
            line_d = '0;
            pack_d = '0;
        end else if (state_q == S_CAPTURE) begin
            if (vrise) begin
                // Frame end: flush a partial byte, then report the line count.
                if (line_ok && cap_x[1:0] != 2'd0) begin
                    push       = 1'b1;
                    push_entry = '{addr: line_base + ADDR_W'(cap_x[7:2]), data: pack_q};
                end
                pack_d = '0;
                x_d    = '0;
                mh_d   = line_q;
            end else if (hrise && x_q != 8'd0) begin
                // Line end: flush a partial byte; unused high bits are already zero.
                if (line_ok && cap_x[1:0] != 2'd0) begin
                    push       = 1'b1;
                    push_entry = '{addr: line_base + ADDR_W'(cap_x[7:2]), data: pack_q};
                end
                mw_d   = cap_x;
                line_d = (line_q == 8'hFF) ? line_q : line_q + 8'd1;
                x_d    = '0;
                pack_d = '0;
            end else if (active) begin
                if (x_q < MAX_W8 && line_ok) begin
                    if (x_q[1:0] == 2'd3) begin
                        push       = 1'b1;
                        push_entry = '{addr: line_base + ADDR_W'(x_q[7:2]),
                                       data: {pixel, pack_q[5:0]}};
                        pack_d     = '0;
                    end else begin
                        pack_d[{x_q[1:0], 1'b0} +: 2] = pixel;
                    end
                end
                x_d = (x_q == 8'hFF) ? x_q : x_q + 8'd1;
            end
        end
    end

    // State, counters, measurements and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            line_q      <= '0;
            pack_q      <= '0;
            meas_width  <= '0;
            meas_height <= '0;
            overflow    <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            line_q      <= line_d;
            pack_q      <= pack_d;
            meas_width  <= mw_d;
            meas_height <= mh_d;
            if (start)
                overflow <= 1'b0;
            else if (push && fifo_full && !pop)
                overflow <= 1'b1;
        end
    end

    // FIFO pointers and occupancy; a push into a full FIFO is kept only with a pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(pop);
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

`ifdef LCD_CAPTURE_CRC_EN
    logic [15:0] crc_q;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++)
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    // Running CRC over accepted bytes, published when the frame completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q     <= 16'hFFFF;
            frame_crc <= 16'hFFFF;
        end else begin
            if (start)
                crc_q <= 16'hFFFF;
            else if (pop)
                crc_q <= crc_step(crc_q, wr_data);
            if (frame_done)
                frame_crc <= crc_q;
        end
    end
`endif

endmodule

// File: tb/tb_lcd_frame_capture.sv
// tb_lcd_frame_capture: randomized frames checked against a frame-level model
// that lists every expected framebuffer write.
`timescale 1ns/1ps
module tb_lcd_frame_capture;

    localparam int MAX_W      = 160;
    localparam int MAX_H      = 160;
    localparam int STRIDE     = 40;
    localparam int ADDR_W     = 13;
    localparam int FIFO_DEPTH = 4;
    localparam int W          = ADDR_W + 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ce_pix = 1'b0;
    logic [1:0]        pixel = 2'd0;
    logic              hblank = 1'b1;
    logic              vblank = 1'b1;
    logic              enable = 1'b0;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_valid;
    logic              wr_ready = 1'b1;
    logic              busy, frame_done, overflow;
    logic [7:0]        meas_width, meas_height;
    logic [1:0]        state_dbg;
`ifdef LCD_CAPTURE_CRC_EN
    logic [15:0]       frame_crc;
    logic [15:0]       first_crc;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int done_exp = 0;
    int wr_cnt   = 0;
    int ready_mode = 0;
    logic [W-1:0] exp_q[$];
    int exp_mw, exp_mh;
    logic [15:0] exp_crc;
    logic [1:0] pix [0:199][0:199];
    int lw [0:199];
    bit prev_stall = 1'b0;
    logic [W-1:0] prev_word = '0;

    lcd_frame_capture #(
        .MAX_W(MAX_W), .MAX_H(MAX_H), .STRIDE(STRIDE),
        .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .pixel(pixel),
        .hblank(hblank), .vblank(vblank), .enable(enable),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .busy(busy), .frame_done(frame_done),
        .overflow(overflow), .meas_width(meas_width), .meas_height(meas_height),
`ifdef LCD_CAPTURE_CRC_EN
        .frame_crc(frame_crc),
`endif
        .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference CRC-16-CCITT, processed one input bit at a time.
    function automatic logic [15:0] crc_model(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        logic fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = c << 1;
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Memory-side ready: 0 always ready, 1 random (75%), 2 stalled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = ($urandom_range(0, 3) != 0);
                default: wr_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard: every accepted write must match the head of exp_q; stalled writes must hold.
    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (prev_stall) begin
            check_eq("hold_valid", 32'(wr_valid), 32'd1);
            check_eq("hold_word", 32'({wr_addr, wr_data}), 32'(prev_word));
        end
        if (wr_valid && wr_ready) begin
            wr_cnt++;
            if (exp_q.size() == 0)
                check_eq("unexpected_write", 32'({wr_addr, wr_data}), 32'hFFFF_FFFF);
            else
                check_eq("write", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
        end
        prev_stall = wr_valid && !wr_ready && !reset;
        prev_word  = {wr_addr, wr_data};
    end

    // Fill the frame arrays: mode 0 pixel=x%4, 1 all 3, 2 random.
    task automatic gen_frame(input int h, input int wmin, input int wmax, input int mode);
        for (int l = 0; l < h; l++) begin
            lw[l] = $urandom_range(wmin, wmax);
            for (int x = 0; x < lw[l]; x++) begin
                case (mode)
                    0:       pix[l][x] = 2'(x);
                    1:       pix[l][x] = 2'd3;
                    default: pix[l][x] = 2'($urandom_range(0, 3));
                endcase
            end
        end
    endtask

    // Model: expected writes, measurements and CRC of the captured frame.
    task automatic build_expect(input int h, input bit drop_l0, input int stop_line);
        int cl, cap, nb, a;
        logic [7:0] d;
        cl = 0;
        exp_mw = 0;
        exp_crc = 16'hFFFF;
        for (int l = 0; l < h; l++) begin
            if (stop_line >= 0 && l >= stop_line) break;
            cap = (lw[l] > MAX_W) ? MAX_W : lw[l];
            if (cl < MAX_H) begin
                nb = (cap + 3) / 4;
                for (int b = 0; b < nb; b++) begin
                    d = 8'h00;
                    for (int k = 0; k < 4; k++)
                        if (4 * b + k < cap) d = d | (8'(pix[l][4 * b + k]) << (2 * k));
                    if (!(drop_l0 && cl == 0 && b >= FIFO_DEPTH)) begin
                        a = (cl * STRIDE + b) % (1 << ADDR_W);
                        exp_q.push_back({ADDR_W'(a), d});
                        exp_crc = crc_model(exp_crc, d);
                    end
                end
            end
            exp_mw = cap;
            if (cl < 255) cl++;
        end
        exp_mh = cl;
    endtask

    // One pixel-clock sample, held for ce_div clocks with ce_pix high in the first.
    task automatic samp(input logic hb, input logic vb, input logic [1:0] px, input int ce_div);
        for (int c = 0; c < ce_div; c++) begin
            @(posedge clk);
            #1;
            ce_pix = (c == 0);
            hblank = hb;
            vblank = vb;
            pixel  = px;
        end
    endtask

    // Drive one frame from the arrays, with optional mid-frame events.
    task automatic send_frame(input int h, input int ce_div, input int en_line,
                              input int rst_line, input bit ovf);
        repeat (4) samp(1'b1, 1'b1, 2'd0, ce_div);
        repeat (4) samp(1'b1, 1'b0, 2'd0, ce_div);
        for (int l = 0; l < h; l++) begin
            if (l == en_line) enable = 1'b1;
            if (ovf && l == 0) ready_mode = 2;
            if (ovf && l == 1) ready_mode = 0;
            if (l == rst_line) ready_mode = 2;
            for (int x = 0; x < lw[l]; x++) begin
                if (l == rst_line && x == 8) begin
                    ce_pix = 1'b0;
                    check_eq("rst_pending_write", 32'(wr_valid), 32'd1);
                    reset = 1'b1;
                    @(posedge clk);
                    #1;
                    reset = 1'b0;
                    check_eq("rst_busy", 32'(busy), 32'd0);
                    check_eq("rst_wr_valid", 32'(wr_valid), 32'd0);
                    ready_mode = 0;
                end
                samp(1'b0, 1'b0, pix[l][x], ce_div);
            end
            repeat (4) samp(1'b1, 1'b0, 2'd0, ce_div);
        end
        repeat (6) samp(1'b1, 1'b1, 2'd0, ce_div);
        @(posedge clk);
        #1;
        ce_pix = 1'b0;
    endtask

    // Wait (bounded) for the frame to finish and check the frame-level results.
    task automatic end_frame(input string tag, input bit exp_ovf);
        int t;
        done_exp++;
        t = 0;
        while (done_cnt < done_exp && t < 5000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        check_eq({tag, "_done_count"}, 32'(done_cnt), 32'(done_exp));
        check_eq({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_meas_width"}, 32'(meas_width), 32'(exp_mw));
        check_eq({tag, "_meas_height"}, 32'(meas_height), 32'(exp_mh));
        check_eq({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
`ifdef LCD_CAPTURE_CRC_EN
        check_eq({tag, "_crc"}, 32'(frame_crc), 32'(exp_crc));
`endif
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_wr_valid", 32'(wr_valid), 32'd0);
        check_eq("reset_wr_addr", 32'(wr_addr), 32'd0);
        check_eq("reset_wr_data", 32'(wr_data), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_frame_done", 32'(frame_done), 32'd0);
        check_eq("reset_overflow", 32'(overflow), 32'd0);
        check_eq("reset_meas_width", 32'(meas_width), 32'd0);
        check_eq("reset_meas_height", 32'(meas_height), 32'd0);
`ifdef LCD_CAPTURE_CRC_EN
        check_eq("reset_frame_crc", 32'(frame_crc), 32'hFFFF);
`endif
        reset = 1'b0;

        // Full 160x160 frame, pixel = x[1:0], always ready
        enable = 1'b1;
        ready_mode = 0;
        gen_frame(160, 160, 160, 0);
        build_expect(160, 1'b0, -1);
        wr_cnt = 0;
        send_frame(160, 1, -1, -1, 1'b0);
        end_frame("full", 1'b0);
        check_eq("full_write_count", 32'(wr_cnt), 32'd6400);

        // 158-pixel lines of pixel 3, random backpressure
        ready_mode = 1;
        gen_frame(4, 158, 158, 1);
        build_expect(4, 1'b0, -1);
        send_frame(4, 1, -1, -1, 1'b0);
        end_frame("w158", 1'b0);

        // Oversized frame: width and height beyond the capture limits
        gen_frame(163, 150, 170, 2);
        build_expect(163, 1'b0, -1);
        send_frame(163, 1, -1, -1, 1'b0);
        end_frame("limits", 1'b0);

        // Line 0 fully stalled: FIFO keeps 4 bytes, the rest drop
        ready_mode = 0;
        gen_frame(3, 160, 160, 2);
        build_expect(3, 1'b1, -1);
        send_frame(3, 1, -1, -1, 1'b1);
        end_frame("ovf", 1'b1);
        gen_frame(5, 10, 40, 2);
        build_expect(5, 1'b0, -1);
        send_frame(5, 1, -1, -1, 1'b0);
        end_frame("ovf_clear", 1'b0);

        // Armed capture abandons when enable drops
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("disarm_idle", 32'(busy), 32'd0);
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("arm_busy", 32'(busy), 32'd1);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("disarm_idle2", 32'(busy), 32'd0);

        // Enable raised mid-frame: no writes until the next frame
        gen_frame(90, 8, 8, 2);
        send_frame(90, 1, 80, -1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check_eq("mid_enable_armed", 32'(busy), 32'd1);
        check_eq("mid_enable_no_done", 32'(done_cnt), 32'(done_exp));
        gen_frame(6, 10, 40, 2);
        build_expect(6, 1'b0, -1);
        send_frame(6, 1, -1, -1, 1'b0);
        end_frame("after_mid", 1'b0);

        // Pixel enable 1 in 3 clocks with held inputs
        ready_mode = 1;
        gen_frame(8, 5, 40, 2);
        build_expect(8, 1'b0, -1);
        send_frame(8, 3, -1, -1, 1'b0);
        end_frame("ce3", 1'b0);

        // Reset at line 50 with a write pending
        ready_mode = 0;
        gen_frame(60, 20, 20, 2);
        build_expect(60, 1'b0, 50);
        send_frame(60, 1, -1, 50, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check_eq("rst_writes_left", 32'(exp_q.size()), 32'd0);
        check_eq("rst_no_done", 32'(done_cnt), 32'(done_exp));
        gen_frame(5, 10, 40, 2);
        build_expect(5, 1'b0, -1);
        send_frame(5, 1, -1, -1, 1'b0);
        end_frame("post_rst", 1'b0);

`ifdef LCD_CAPTURE_CRC_EN
        // Two identical frames give the same CRC
        ready_mode = 1;
        gen_frame(5, 10, 30, 2);
        build_expect(5, 1'b0, -1);
        send_frame(5, 1, -1, -1, 1'b0);
        end_frame("crc_a", 1'b0);
        first_crc = frame_crc;
        build_expect(5, 1'b0, -1);
        send_frame(5, 1, -1, -1, 1'b0);
        end_frame("crc_b", 1'b0);
        check_eq("crc_repeat", 32'(frame_crc), 32'(first_crc));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_frame_capture.md
Name: lcd_frame_capture

Overview:
- Sink-side counterpart of the LCD scan-out path.
- Consumes the 2bpp pixel stream (ce_pix, pixel, hblank, vblank) and packs 4 pixels per byte, using the same bit order the scan-out uses to unpack VRAM bytes.
- Writes the packed bytes through a small FIFO to a linear capture framebuffer using a valid/ready write port.
- Used for screenshot/frame-dump and as a loopback checker for the LCD controller.

Parameters:
- MAX_W, 160, max active pixels captured per line; extra pixels dropped.
- MAX_H, 160, max active lines captured per frame; extra lines dropped.
- STRIDE, 40, framebuffer bytes per line (≥ MAX_W/4).
- ADDR_W, 13, framebuffer address width.
- FIFO_DEPTH, 4, write FIFO entries (power of 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ce_pix  in  1  pixel-clock enable; inputs sampled only when high
- pixel  in  2  pixel value
- hblank  in  1  horizontal blank
- vblank  in  1  vertical blank
- enable  in  1  capture request; sampled at frame start only
- wr_addr  out  ADDR_W  framebuffer byte address
- wr_data  out  8  packed byte
- wr_valid  out  1  write request
- wr_ready  in  1  memory accepts when wr_valid&&wr_ready
- busy  out  1  state != IDLE
- frame_done  out  1  one-clk pulse, frame fully written
- overflow  out  1  sticky: byte dropped on FIFO full this frame
- meas_width  out  8  active pixels in last captured line
- meas_height  out  8  active lines in last captured frame

Behaviour:
- Reset values: wr_addr=0, wr_data=0, wr_valid=0, busy=0, frame_done=0, overflow=0, meas_width=0, meas_height=0, FIFO empty, state=IDLE.
- Active pixel definition: ce_pix && !hblank && !vblank. Edges of hblank/vblank are detected only on ce_pix cycles, against the previously sampled value.
- State machine:
  - IDLE -> ARMED when enable=1.
  - ARMED -> CAPTURE on a vblank falling edge. On entry: line=0, x=0, overflow cleared.
  - ARMED -> IDLE if enable drops.
  - CAPTURE -> DRAIN on a vblank rising edge. On this transition: flush any partial byte, then latch meas_height=line.
  - DRAIN -> IDLE when the FIFO is empty and wr_valid=0. In that cycle frame_done pulses for one clk.
  - enable asserting mid-frame does not start capture before the next vblank fall.
  - enable dropping during CAPTURE or DRAIN does not abort; the frame completes.
- Packing:
  - Pixel k of a byte (k = x[1:0]) goes to bits [2k+1:2k]; pixel 0 lands in bits [1:0].
  - On the 4th pixel, the byte is pushed with address line*STRIDE + x[7:2]. Computed in ADDR_W bits; product truncated.
- Line end (hblank rising edge in CAPTURE, after ≥1 active pixel on the line):
  - A partial byte is pushed with unused high bits zero.
  - meas_width=x (saturating at MAX_W); line increments; x=0.
  - Lines with zero active pixels do not increment line.
- Limits:
  - Pixels with x ≥ MAX_W are ignored.
  - Lines with line ≥ MAX_H are ignored, but still counted into meas_height, saturating at 255.
- FIFO:
  - Push on byte complete; pop on wr_valid && wr_ready.
  - Push and pop in the same cycle are allowed when full.
  - Push when full without a simultaneous pop drops the byte and sets overflow (sticky until the next capture start).
  - Latency: byte complete -> wr_valid high on the next clk when the FIFO was empty.
  - wr_addr/wr_data are stable while wr_valid && !wr_ready.
- Reset mid-operation:
  - Immediate return to IDLE and FIFO flushed.
  - No frame_done is issued.
  - A pending write is abandoned; wr_valid drops the next cycle.

Optional Feature:
- Macro: LCD_CAPTURE_CRC_EN.
- When defined:
  - Adds output frame_crc[15:0]: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) over every byte accepted by the memory (wr_valid&&wr_ready) in the frame.
  - Updated on accept; latched to frame_crc in the frame_done cycle; reset value 0xFFFF.
- When undefined: no port, no CRC logic.

Test Plan:
- 160x160 frame, pixel=x[1:0], wr_ready=1, enable=1 before vblank fall -> 6400 writes, each wr_data=0xE4, addr 0..39 on line 0 and 40..79 on line 1; last addr 6399; one frame_done; meas_width=160; meas_height=160; overflow=0.
- 158-pixel lines, all pixels=3 -> 40 bytes/line, last byte 0x0F at line*40+39; meas_width=158.
- wr_ready=0 for the whole of line 0 -> FIFO holds 4 bytes; the remaining 36 bytes of line 0 are dropped; overflow=1; frame_done still pulses after the drain; overflow clears at the next capture start.
- enable raised mid-frame (line 80) -> no writes until the next vblank fall, then a full frame with addr starting at 0.
- ce_pix high 1 in 3 clks, pixels held for 3 clks -> identical write count and data to the first scenario (no double sampling).
- reset asserted at line 50 with wr_valid=1 -> busy=0 and wr_valid=0 next clk; no frame_done; the next frame is captured normally. With LCD_CAPTURE_CRC_EN, two identical frames -> equal frame_crc.
